// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for a five-stage pipeline. Combines load-use,
// taken-branch and data-memory-wait hazards into per-stage register controls,
// gates the pipeline on Start, traps on a memory-wait timeout and keeps a
// saturating stall-cycle counter.
//
// Ports:
//   Clk, Rst              clock, asynchronous active-high reset
//   Start                 run enable (0 freezes the pipeline)
//   IDEX_MemRead, IDEX_Rt load in EX and its destination register
//   IFID_Rs, IFID_Rt      source registers of the instruction in ID
//   Branch_taken          branch in ID resolved taken
//   Dmem_req, Dmem_ready  data-memory handshake at EX/MEM
//   PC_Write .. EXMEM_Write  register load enables
//   IFID_Flush, IDEX_Bubble, MEMWB_Bubble  flush / bubble controls
//   Err                   sticky memory-timeout error
//   StallCnt              saturating stall-cycle count
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             Branch_taken,
  input  logic             Dmem_req,
  input  logic             Dmem_ready,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             EXMEM_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             MEMWB_Bubble,
  output logic             Err,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2,
    ERROR   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mem_stall;
  logic active;

  // Hazard terms
  assign load_use  = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                     ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
  assign mem_stall = Dmem_req && !Dmem_ready;
  // Rst gating keeps outputs quiet for the whole reset pulse, not just after the edge
  assign active    = !Rst && ((state_q == RUN) || (state_q == MEMWAIT));

  // State and wait counter register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if ((state_q != ERROR) && !Start) begin
      state_d    = IDLE;
      wait_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (mem_stall) begin
            state_d    = MEMWAIT;
            wait_cnt_d = WAIT_W'(1);
          end
        end
        MEMWAIT: begin
          // Ready wins over an expiring timeout
          if (Dmem_ready) begin
            state_d    = RUN;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
            state_d = ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        ERROR: state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    PC_Write     = 1'b0;
    IFID_Write   = 1'b0;
    IDEX_Write   = 1'b0;
    EXMEM_Write  = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    MEMWB_Bubble = 1'b0;
    if (active) begin
      if (mem_stall) begin
        // Full hold: load-use and branch are re-evaluated after release
        MEMWB_Bubble = 1'b1;
      end else begin
        IDEX_Write  = 1'b1;
        EXMEM_Write = 1'b1;
        if (load_use) begin
          IDEX_Bubble = 1'b1;
        end else begin
          PC_Write   = 1'b1;
          IFID_Write = 1'b1;
          IFID_Flush = Branch_taken;
        end
      end
    end
  end

  // Saturating stall counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (active && !PC_Write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign Err      = (state_q == ERROR);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             Start;
  logic             IDEX_MemRead;
  logic [4:0]       IDEX_Rt;
  logic [4:0]       IFID_Rs;
  logic [4:0]       IFID_Rt;
  logic             Branch_taken;
  logic             Dmem_req;
  logic             Dmem_ready;
  logic             PC_Write, IFID_Write, IDEX_Write, EXMEM_Write;
  logic             IFID_Flush, IDEX_Bubble, MEMWB_Bubble;
  logic             Err;
  logic [CNT_W-1:0] StallCnt;

  int n_checks = 0;
  int n_fails  = 0;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .Branch_taken(Branch_taken), .Dmem_req(Dmem_req), .Dmem_ready(Dmem_ready),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
    .EXMEM_Write(EXMEM_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .MEMWB_Bubble(MEMWB_Bubble),
    .Err(Err), .StallCnt(StallCnt)
  );

  always #5 Clk = ~Clk;

  // {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, IFID_Flush, IDEX_Bubble, MEMWB_Bubble}
  logic [6:0] ctrl;
  assign ctrl = {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write,
                 IFID_Flush, IDEX_Bubble, MEMWB_Bubble};

  localparam logic [6:0] C_OFF  = 7'b0000000;
  localparam logic [6:0] C_RUN  = 7'b1111000;
  localparam logic [6:0] C_BR   = 7'b1111100;
  localparam logic [6:0] C_LU   = 7'b0011010;
  localparam logic [6:0] C_HOLD = 7'b0000001;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1: check comb controls mid-cycle, then registered state after the edge
  task automatic cycle(input string tag, input logic [6:0] exp_ctrl,
                       input int exp_cnt, input logic exp_err);
    #2;
    check_eq({tag, ".ctrl"}, 32'(ctrl), 32'(exp_ctrl));
    @(posedge Clk); #1;
    check_eq({tag, ".cnt"}, 32'(StallCnt), 32'(exp_cnt));
    check_eq({tag, ".err"}, 32'(Err), 32'(exp_err));
  endtask

  // Asynchronous reset pulse, checked before any clock edge
  task automatic async_reset(input string tag);
    Rst = 1'b1;
    #1;
    check_eq({tag, ".ctrl"}, 32'(ctrl), 32'(C_OFF));
    check_eq({tag, ".cnt"}, 32'(StallCnt), 32'd0);
    check_eq({tag, ".err"}, 32'(Err), 32'd0);
    @(posedge Clk); #1;
    check_eq({tag, ".hold"}, 32'(ctrl), 32'(C_OFF));
    Rst = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0;
    IFID_Rs = 5'd0; IFID_Rt = 5'd0; Branch_taken = 1'b0;
    Dmem_req = 1'b0; Dmem_ready = 1'b0;
    #1;
    check_eq("rst.ctrl", 32'(ctrl), 32'(C_OFF));
    check_eq("rst.cnt", 32'(StallCnt), 32'd0);
    check_eq("rst.err", 32'(Err), 32'd0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst = 1'b0;

    for (int i = 0; i < 3; i++) cycle("idle", C_OFF, 0, 1'b0);
    Start = 1'b1;
    cycle("start_idle", C_OFF, 0, 1'b0);
    cycle("run", C_RUN, 0, 1'b0);

    // Load-use via Rs, then suppressed by Rt=0, then via Rt
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
    cycle("lu_rs", C_LU, 1, 1'b0);
    IDEX_Rt = 5'd0; IFID_Rs = 5'd0;
    cycle("lu_r0", C_RUN, 1, 1'b0);
    IDEX_Rt = 5'd5; IFID_Rt = 5'd5;
    cycle("lu_rt", C_LU, 2, 1'b0);

    // Branch alone flushes; load-use beats branch
    IDEX_MemRead = 1'b0; Branch_taken = 1'b1;
    cycle("br", C_BR, 2, 1'b0);
    IDEX_MemRead = 1'b1;
    cycle("br_lu", C_LU, 3, 1'b0);
    IDEX_MemRead = 1'b0; Branch_taken = 1'b0; IDEX_Rt = 5'd0; IFID_Rt = 5'd0;

    // Three non-ready cycles then release; hazards suppressed during hold
    Dmem_req = 1'b1; Dmem_ready = 1'b0;
    cycle("mh1", C_HOLD, 4, 1'b0);
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8; Branch_taken = 1'b1;
    cycle("mh2", C_HOLD, 5, 1'b0);
    IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; Branch_taken = 1'b0;
    cycle("mh3", C_HOLD, 6, 1'b0);
    Dmem_ready = 1'b1;
    cycle("mrel", C_RUN, 6, 1'b0);
    Dmem_req = 1'b0; Dmem_ready = 1'b0;
    cycle("run5", C_RUN, 6, 1'b0);

    // Ready in RUN: no stall
    Dmem_req = 1'b1; Dmem_ready = 1'b1;
    cycle("rdy_run", C_RUN, 6, 1'b0);

    // Ready arriving when wait_cnt == TIMEOUT wins
    Dmem_ready = 1'b0;
    cycle("to_h0", C_HOLD, 7, 1'b0);
    cycle("to_h1", C_HOLD, 8, 1'b0);
    cycle("to_h2", C_HOLD, 9, 1'b0);
    cycle("to_h3", C_HOLD, 10, 1'b0);
    Dmem_ready = 1'b1;
    cycle("rdy_to", C_RUN, 10, 1'b0);
    Dmem_req = 1'b0; Dmem_ready = 1'b0;
    cycle("after_to", C_RUN, 10, 1'b0);

    // Start drop during MEMWAIT, then restart re-evaluates mem_stall
    Dmem_req = 1'b1;
    cycle("mw_in", C_HOLD, 11, 1'b0);
    Start = 1'b0;
    cycle("mw_stop", C_HOLD, 12, 1'b0);
    cycle("stopped", C_OFF, 12, 1'b0);
    Start = 1'b1;
    cycle("restart_idle", C_OFF, 12, 1'b0);
    cycle("restart_hold", C_HOLD, 13, 1'b0);

    // Reset in MEMWAIT with request still pending
    async_reset("rst_mw");
    Dmem_req = 1'b0;
    cycle("post_rst", C_OFF, 0, 1'b0);

    // Timeout: ERROR after 4 MEMWAIT cycles
    Dmem_req = 1'b1; Dmem_ready = 1'b0;
    cycle("tmo_run", C_HOLD, 1, 1'b0);
    cycle("tmo_w1", C_HOLD, 2, 1'b0);
    cycle("tmo_w2", C_HOLD, 3, 1'b0);
    cycle("tmo_w3", C_HOLD, 4, 1'b0);
    cycle("tmo_w4", C_HOLD, 5, 1'b1);
    Dmem_req = 1'b0; IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
    cycle("err_a", C_OFF, 5, 1'b1);
    Start = 1'b0;
    cycle("err_b", C_OFF, 5, 1'b1);
    Start = 1'b1; Dmem_ready = 1'b1;
    cycle("err_c", C_OFF, 5, 1'b1);
    Dmem_ready = 1'b0;
    async_reset("rst_err");

    // Saturation at 15 with continuous load-use
    cycle("sat_idle", C_OFF, 0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      cycle($sformatf("sat%0d", i), C_LU, (i > 15) ? 15 : i, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. It produces the write-enable, bubble and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB from three hazard sources:
- load-use hazards;
- taken branches resolved in ID;
- a variable-latency data-memory handshake at the EX/MEM boundary.

It also gates the whole pipeline on `Start`, enforces a memory-wait timeout and keeps a saturating stall-cycle counter for performance checks.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum consecutive MEMWAIT cycles before an error trap; range 1..255.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `Clk`  in  1  pipeline clock; all state updates on rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `Start`  in  1  run enable; 0 freezes the pipeline.
- `IDEX_MemRead`  in  1  instruction in EX is a load.
- `IDEX_Rt`  in  5  destination register of that load.
- `IFID_Rs`, `IFID_Rt`  in  5 each  source registers of the instruction in ID.
- `Branch_taken`  in  1  branch in ID resolved taken.
- `Dmem_req`  in  1  EX/MEM instruction accesses data memory this cycle.
- `Dmem_ready`  in  1  data memory completes the access this cycle.
- `PC_Write`, `IFID_Write`, `IDEX_Write`, `EXMEM_Write`  out  1 each  register load enables.
- `IFID_Flush`  out  1  zero IF/ID on next edge.
- `IDEX_Bubble`  out  1  load NOP controls into ID/EX.
- `MEMWB_Bubble`  out  1  load NOP controls into MEM/WB.
- `Err`  out  1  sticky memory-timeout error.
- `StallCnt`  out  CNT_W  saturating count of stall cycles.

## Operation
States:
- IDLE=0: pipeline frozen.
- RUN=1: normal flow.
- MEMWAIT=2: waiting on data memory.
- ERROR=3: trapped.

Hazard terms, evaluated combinationally every cycle:
- `load_use` = `IDEX_MemRead` & (`IDEX_Rt`≠0) & (`IDEX_Rt`==`IFID_Rs` | `IDEX_Rt`==`IFID_Rt`).
- `mem_stall` = `Dmem_req` & !`Dmem_ready`.

Outputs by state:
- IDLE, ERROR: every enable, bubble and flush output is 0.
- RUN or MEMWAIT with `mem_stall`=1 (full hold):
  - `PC_Write`, `IFID_Write`, `IDEX_Write` and `EXMEM_Write` are 0.
  - `MEMWB_Bubble`=1.
  - `IFID_Flush`=0 and `IDEX_Bubble`=0. Load-use and branch are suppressed and re-evaluated once the hold releases.
- RUN or MEMWAIT with `mem_stall`=0:
  - `IDEX_Write`=1 and `EXMEM_Write`=1; `MEMWB_Bubble`=0.
  - If `load_use`=1: `PC_Write`=0, `IFID_Write`=0, `IDEX_Bubble`=1, `IFID_Flush`=0. `load_use` beats branch.
  - Else: `PC_Write`=1, `IFID_Write`=1, `IDEX_Bubble`=0, and `IFID_Flush`=`Branch_taken`.

Transitions, evaluated in priority order:
- Any state except ERROR with `Start`=0 goes to IDLE.
- IDLE with `Start`=1 goes to RUN.
- RUN with `mem_stall`=1 goes to MEMWAIT, and `wait_cnt` is set to 1.
- MEMWAIT:
  - `Dmem_ready`=1: go to RUN and clear `wait_cnt`. This cycle is the release cycle and uses the `mem_stall`=0 outputs.
  - Else, if `wait_cnt`==`TIMEOUT`: go to ERROR.
  - Else: increment `wait_cnt`.
- ERROR is left only by `Rst`. `Err`=1 whenever the state is ERROR.

Stall counter:
- A stall cycle is any cycle in RUN or MEMWAIT with `PC_Write`=0.
- `StallCnt` increments on every stall cycle and saturates at all-ones without wrapping.
- IDLE and ERROR cycles are not counted.

## Timing
- Reset is asynchronous:
  - state becomes IDLE, with `wait_cnt`=0, `StallCnt`=0 and `Err`=0;
  - all enable, bubble and flush outputs are 0 while `Rst` is high.
- Reset mid-MEMWAIT abandons the access; no output glitches to 1 while `Rst` is high.
- First RUN cycle is the cycle after `Start` is sampled 1; the pipeline freezes the cycle after `Start` is sampled 0.
- Hazard outputs are combinational from inputs and state; there is no added latency.
- Load-use costs exactly 1 stall cycle per hazard.
- Branch flush costs 1 cycle and no stall.
- A memory access with N non-ready cycles costs N stall cycles.
- If `Dmem_ready`=1 with `Dmem_req`=1 in RUN, there is no stall.
- `Dmem_ready` arriving in the same cycle that `wait_cnt`==`TIMEOUT` counts as success; ready beats timeout.
- `Start`=0 during MEMWAIT goes to IDLE. On the next `Start`=1 the FSM re-enters RUN and re-evaluates `mem_stall`.

## Test plan
- Reset, then `Start`=0 for 3 cycles:
  - state IDLE; all outputs 0; `StallCnt`=0.
  - Raise `Start`: next cycle `PC_Write`=`IFID_Write`=`IDEX_Write`=`EXMEM_Write`=1.
- `IDEX_MemRead`=1, `IDEX_Rt`=8, `IFID_Rs`=8, one cycle:
  - `PC_Write`=0, `IFID_Write`=0, `IDEX_Bubble`=1; `StallCnt`=1.
  - Repeat with `IDEX_Rt`=0: no stall.
- `Branch_taken`=1 with no `load_use`: `IFID_Flush`=1 and `PC_Write`=1.
  - Same cycle with `load_use`=1: `IFID_Flush`=0 and `IDEX_Bubble`=1.
- `Dmem_req`=1 with `Dmem_ready` low for 3 cycles, then high:
  - 3 hold cycles with `EXMEM_Write`=0 and `MEMWB_Bubble`=1, then release.
  - State RUN on the 5th cycle; `StallCnt` increases by 3.
- `TIMEOUT`=4 with `Dmem_ready` held 0:
  - ERROR entered after 4 MEMWAIT cycles; `Err`=1 sticky.
  - `Start` toggling has no effect until `Rst`, which clears `Err`, `StallCnt` and state asynchronously.
- `CNT_W`=4 with 20 consecutive load-use stalls: `StallCnt` saturates at 15.
